// File: rtl/mem_stream_reader_if.sv
// Memory read port plus valid/ready output stream of mem_stream_reader.
//   mem_re/mem_addr : read request toward the ROM
//   mem_data        : ROM read data, valid the cycle after mem_re
//   out_data/out_valid/out_ready : output stream toward the consumer
// master = reader side, slave = ROM/consumer side.
interface mem_stream_reader_if #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 16
);
  logic                  mem_re;
  logic [WIDTH_ADDR-1:0] mem_addr;
  logic [WIDTH_DATA-1:0] mem_data;
  logic [WIDTH_DATA-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output mem_re, mem_addr, out_data, out_valid,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_re, mem_addr, out_data, out_valid,
    output mem_data, out_ready
  );
endinterface

// File: rtl/mem_stream_reader.sv
// Sequential read master for a one-cycle-latency ROM. A start command fetches
// `length` consecutive words from `base_addr` and streams them out through a
// 2-entry buffer that absorbs read latency and consumer backpressure.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : command strobe (IDLE only), cancel transfer
//   base_addr, length : transfer parameters, sampled with start
//   busy, done        : transfer in progress, one-cycle end pulse
//   bus               : ROM read port and output stream (master modport)
//
// state | meaning
// IDLE  | waiting for start
// READ  | reads still to be issued
// DRAIN | all reads issued, buffer or in-flight word not yet empty
module mem_stream_reader #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH_ADDR-1:0] base_addr,
  input  logic [WIDTH_ADDR:0]   length,
  output logic                  busy,
  output logic                  done,
  mem_stream_reader_if.master   bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [WIDTH_ADDR-1:0] ptr_q, ptr_d;
  logic [WIDTH_ADDR:0]   rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [WIDTH_DATA-1:0] buf0_q, buf0_d;
  logic [WIDTH_DATA-1:0] buf1_q, buf1_d;
  logic                  done_q, done_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] occ_after;

  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = buf0_q;
  assign pop           = bus.out_valid & bus.out_ready;
  assign push          = inflight_q;

  // Occupancy left after this cycle's pop; a new read may only be issued
  // if it still fits, which makes buffer overflow impossible.
  assign occ_after = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue     = (state_q == READ) && (occ_after < 2'd2);

  assign bus.mem_re   = issue;
  assign bus.mem_addr = ptr_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    done_d     = 1'b0;
    inflight_d = issue;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};

    // Head is always buf0; buf1 only holds a word when two are buffered.
    if (pop) begin
      if (cnt_q == 2'd2) begin
        buf0_d = buf1_q;
        if (push) buf1_d = bus.mem_data;
      end else if (push) begin
        buf0_d = bus.mem_data;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) buf0_d = bus.mem_data;
      else               buf1_d = bus.mem_data;
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (length != '0) begin
            ptr_d   = base_addr;
            rem_d   = length;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (WIDTH_ADDR+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (cnt_d == 2'd0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The word returning from an in-flight read is dropped with the buffer.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      cnt_d      = 2'd0;
      inflight_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed self-checking bench for mem_stream_reader with a one-cycle ROM model.
module tb_mem_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic [16:0] length;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] got[$];

  mem_stream_reader_if #(.WIDTH_DATA(32), .WIDTH_ADDR(16)) bus ();

  mem_stream_reader #(.WIDTH_DATA(32), .WIDTH_ADDR(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [15:0] a);
    return {a ^ 16'hC35A, a};
  endfunction

  // ROM: data for a read appears the following cycle, 0 otherwise.
  always @(posedge clk) bus.mem_data <= bus.mem_re ? rom(bus.mem_addr) : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"},      32'(busy),          32'h0);
    check({pfx, "_done"},      32'(done),          32'h0);
    check({pfx, "_mem_re"},    32'(bus.mem_re),    32'h0);
    check({pfx, "_mem_addr"},  32'(bus.mem_addr),  32'h0);
    check({pfx, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    check({pfx, "_out_data"},  bus.out_data,       32'h0);
  endtask

  // Called just after a rising edge; that edge samples start (end of C0).
  task automatic do_start(input logic [15:0] b, input logic [16:0] l);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Exact cycle-by-cycle timing with out_ready held high, starting in C1.
  task automatic run_directed(input logic [15:0] b, input int len);
    logic [15:0] a;
    bus.out_ready = 1'b1;
    for (int cyc = 1; cyc <= len + 4; cyc++) begin
      @(negedge clk);
      check("mem_re", 32'(bus.mem_re), 32'(cyc <= len));
      if (cyc <= len) begin
        a = b + 16'(cyc - 1);
        check("mem_addr", 32'(bus.mem_addr), 32'(a));
      end
      check("out_valid", 32'(bus.out_valid), 32'(cyc >= 3 && cyc <= len + 2));
      if (cyc >= 3 && cyc <= len + 2) begin
        a = b + 16'(cyc - 3);
        check("out_data", bus.out_data, rom(a));
      end
      check("done", 32'(done), 32'(cyc == len + 3));
      check("busy", 32'(busy), 32'(cyc <= len + 2));
      @(posedge clk); #1;
    end
  endtask

  // Collects accepted words until done. ready_mode 1 drives 1,0,0,1,...
  // A spurious start (base 0x0050, length 5) is pulsed in cycle restart_cyc.
  task automatic collect(input int ready_mode, input int restart_cyc);
    int   issued, popped, occ;
    bit   pop, prev_valid, prev_ready, got_done;
    logic [31:0] prev_data;
    got.delete();
    issued = 0; popped = 0; got_done = 0;
    prev_valid = 0; prev_ready = 0; prev_data = '0;
    for (int k = 1; k <= 200 && !got_done; k++) begin
      bus.out_ready = (ready_mode == 0) ? 1'b1 : (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3));
      start = (k == restart_cyc);
      if (start) begin
        base_addr = 16'h0050;
        length    = 17'd5;
      end
      @(negedge clk);
      occ = issued - popped;
      pop = bus.out_valid && bus.out_ready;
      check("occ_le_2", 32'(occ <= 2), 32'h1);
      if (occ - int'(pop) == 2) check("mem_re_when_full", 32'(bus.mem_re), 32'h0);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(bus.out_valid), 32'h1);
        check("hold_data", bus.out_data, prev_data);
      end
      if (bus.mem_re) issued++;
      if (pop) begin
        popped++;
        got.push_back(bus.out_data);
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_data  = bus.out_data;
      if (done) got_done = 1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    check("done_seen", 32'(got_done), 32'h1);
  endtask

  task automatic check_words(input string tag, input logic [15:0] b, input int n);
    logic [15:0] a;
    check({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      a = b + 16'(i);
      check({tag, "_word"}, got[i], rom(a));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; length = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic transfer and address wrap.
    do_start(16'h0010, 17'd4);
    run_directed(16'h0010, 4);
    do_start(16'hFFFE, 17'd4);
    run_directed(16'hFFFE, 4);

    // Backpressure.
    do_start(16'h0100, 17'd8);
    collect(1, 0);
    check_words("bp", 16'h0100, 8);

    // Zero length.
    do_start(16'h0030, 17'd0);
    @(negedge clk);
    check("len0_done", 32'(done), 32'h1);
    check("len0_busy", 32'(busy), 32'h0);
    check("len0_mem_re", 32'(bus.mem_re), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("len0_done_after", 32'(done), 32'h0);
    check("len0_busy_after", 32'(busy), 32'h0);
    @(posedge clk); #1;

    // Start while busy is ignored.
    do_start(16'h0040, 17'd3);
    collect(0, 2);
    check_words("restart", 16'h0040, 3);
    @(negedge clk);
    check("restart_idle_busy", 32'(busy), 32'h0);
    check("restart_idle_re", 32'(bus.mem_re), 32'h0);
    @(posedge clk); #1;

    // Abort with a read in flight.
    do_start(16'h0060, 17'd4);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_valid", 32'(bus.out_valid), 32'h0);
    check("abort_mem_re", 32'(bus.mem_re), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_done2", 32'(done), 32'h0);
    check("abort_valid2", 32'(bus.out_valid), 32'h0);
    @(posedge clk); #1;
    do_start(16'h0020, 17'd2);
    run_directed(16'h0020, 2);

    // Asynchronous reset on the third word.
    do_start(16'h0070, 17'd6);
    repeat (4) @(posedge clk);
    #3;
    check("prerst_valid", 32'(bus.out_valid), 32'h1);
    check("prerst_data", bus.out_data, rom(16'h0072));
    rst_n = 1'b0;
    #1;
    check_quiet("async_rst");
    @(posedge clk);
    @(negedge clk);
    check("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(16'h0080, 17'd3);
    run_directed(16'h0080, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
